// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues reads to a one-cycle-latency instruction memory
// and buffers returned words in order for decode, with flush on redirect.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        ena,
  input  logic        jumpEn,
  output logic        stall,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic [CW-1:0] occupancy_s;
  logic          stall_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;

  // Handshake decode; occupancy counts the read still in flight so it always has a slot.
  always_comb begin
    occupancy_s = count_q + {{(CW-1){1'b0}}, pend_valid_q};
    stall_s     = ~jumpEn & ~reset & (occupancy_s >= CW'(DEPTH));
    issue_s     = ena & ~stall_s & ~jumpEn & ~reset;
    push_s      = pend_valid_q & ~jumpEn;
    pop_s       = (count_q != {CW{1'b0}}) & inst_ready & ~jumpEn;
  end

  assign stall      = stall_s;
  assign imem_en    = issue_s;
  assign imem_addr  = pc;
  assign inst_valid = (count_q != {CW{1'b0}});
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];

  // Next-state for pointers, count and the pending-read tracker; a redirect wipes everything.
  always_comb begin
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    pend_valid_d = issue_s;
    pend_pc_d    = pend_pc_q;
    if (issue_s) begin
      pend_pc_d = pc;
    end else begin
      pend_pc_d = pend_pc_q;
    end
    if (jumpEn) begin
      count_d  = {CW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= {CW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0000_0000;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= pend_pc_q;
    end
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Parameters
REQ-001 SHALL provide parameter DEPTH, default 4, meaning number of buffered instruction entries (power of two, >= 2).

Interface
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pc  input  32  fetch address from the program counter.
REQ-005 SHALL have port ena  input  1  program counter fetch request valid.
REQ-006 SHALL have port jumpEn  input  1  redirect/flush; pc this cycle is wrong-path.
REQ-007 SHALL have port stall  output  1  hold request back to the program counter.
REQ-008 SHALL have port imem_en  output  1  instruction memory read enable.
REQ-009 SHALL have port imem_addr  output  32  instruction memory read address.
REQ-010 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_en.
REQ-011 SHALL have port inst  output  32  head-of-queue instruction word.
REQ-012 SHALL have port inst_pc  output  32  address of inst.
REQ-013 SHALL have port inst_valid  output  1  head entry valid.
REQ-014 SHALL have port inst_ready  input  1  decode accepts head entry.
REQ-015 SHALL use one clock, clk; reset SHALL be synchronous and active-high on port reset.

Function
REQ-016 SHALL compute issue = ena & ~stall & ~jumpEn & ~reset, combinationally.
REQ-017 SHALL drive imem_en = issue and imem_addr = pc combinationally (imem_addr = pc even when not issuing).
REQ-018 SHALL on issue set pend_valid=1 and pend_pc=pc at the clock edge; otherwise pend_valid=0.
REQ-019 SHALL, when pend_valid=1 and jumpEn=0, push {imem_rdata, pend_pc} into the queue at that clock edge.
REQ-020 SHALL drive stall = ~jumpEn & ((count + pend_valid) >= DEPTH), combinationally; never asserted while jumpEn=1, so a redirect is never lost.
REQ-021 SHALL pop head when inst_valid & inst_ready & ~jumpEn; inst_valid = (count != 0).
REQ-022 SHALL present inst/inst_pc from head entry with zero-cycle latency; values when inst_valid=0 are don't-care.
REQ-023 SHALL keep entries in strict issue order; pointers wrap modulo DEPTH.
REQ-024 SHALL on simultaneous push and pop keep count unchanged, advancing both pointers.
REQ-025 SHALL on jumpEn=1 at an edge: clear count and pointers, clear pend_valid, discard the imem_rdata in flight, issue nothing that cycle.
REQ-026 SHALL hold all state when ena=0, pend_valid=0 and no pop occurs.
REQ-027 SHALL never push while full; count SHALL never exceed DEPTH (guaranteed by REQ-020).
REQ-028 Fetch-to-inst_valid latency SHALL be 2 cycles from issue into an empty queue.

Reset
REQ-029 SHALL while reset=1 force imem_en=0, stall=0.
REQ-030 SHALL at a reset edge set count=0, read/write pointers=0, pend_valid=0, pend_pc=0, making inst_valid=0 next cycle.
REQ-031 SHALL let reset take priority over jumpEn, push and pop, including mid-operation with a read in flight (that data discarded).

Verification
REQ-032 Streaming: ena=1, inst_ready=1, pc 0,4,8,... -> imem_en every cycle, inst_valid from cycle 2, inst_pc 0,4,8 in order, stall never 1.
REQ-033 Backpressure: inst_ready=0, DEPTH=4, pc from 0 -> issues 0,4,8,C then stall=1 while count+pend_valid>=4; release inst_ready -> entries 0,4,8,C drain in order, next issue 0x10.
REQ-034 Flush: three entries queued, one pending, jumpEn=1 with jumpVect 0x100 -> next cycle inst_valid=0, stale rdata not pushed, first new entry inst_pc=0x100.
REQ-035 Jump while full: queue full, stall=1, jumpEn=1 -> stall=0 same cycle, queue empty next cycle.
REQ-036 Reset mid-stream: reset=1 with pend_valid=1 and count=2 -> imem_en=0 during reset, inst_valid=0 after, in-flight data never appears on inst.
REQ-037 Push+pop at full: count=4, pop with pending push impossible (stall), pop alone -> count=3, ordering preserved across pointer wrap.
